// File: rtl/ripple_pkg.sv
// Shared widths, FSM encoding and step-period helper for the ripple step-rate controller.
package ripple_pkg;

    localparam int unsigned LEVEL_W   = 3;
    localparam int unsigned MAX_LEVEL = 7;
    localparam int unsigned CNT_W     = 32;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Step period for a level: base divided by 2^lvl, never below one clock.
    function automatic logic [CNT_W-1:0] step_period(input logic [CNT_W-1:0]   base,
                                                     input logic [LEVEL_W-1:0] lvl);
        logic [CNT_W-1:0] p;
        p = base >> lvl;
        return (p == '0) ? CNT_W'(1) : p;
    endfunction

endpackage

// File: rtl/ripple_debounce.sv
// Two-flop synchronizer plus stability-count debouncer with a rising-edge press strobe.
module ripple_debounce
#(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db,
    output logic press
);

    localparam int unsigned DB_W = $clog2(DB_CYCLES + 1);

    logic            s1;
    logic            s2;
    logic            db_q;
    logic [DB_W-1:0] stable_cnt;

    // db follows s2 only after DB_CYCLES consecutive edges of disagreement
    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            db         <= 1'b0;
            db_q       <= 1'b0;
            stable_cnt <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            db_q <= db;
            if (s2 == db) begin
                stable_cnt <= '0;
            end else if (stable_cnt == DB_W'(DB_CYCLES - 1)) begin
                db         <= s2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + DB_W'(1);
            end
        end
    end

    assign press = db & ~db_q;

endmodule

// File: rtl/ripple_rate_ctrl.sv
// Speed-level and step-pulse generator for the rippling LED stage.
// Optional feature: define RIPPLE_SINGLE_STEP_EN for single-step on "faster" while paused.
module ripple_rate_ctrl
    import ripple_pkg::*;
#(
    parameter int unsigned BASE_DIV  = 50_000_000,
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               sw_pause,
    output logic               step,
    output logic [LEVEL_W-1:0] level,
    output logic               paused
);

    localparam logic [CNT_W-1:0] BASE = CNT_W'(BASE_DIV);

    state_t             state;
    state_t             state_n;
    logic [LEVEL_W-1:0] level_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic [CNT_W-1:0]   period_c;
    logic               step_n;
    logic               hold_c;
    logic               lvl_en_c;
    logic               single_c;

    logic up_db, up_press;
    logic down_db, down_press;
    logic pause_db, pause_press;
    logic unused_c;

    ripple_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_up),
        .db    (up_db),
        .press (up_press)
    );

    ripple_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_down),
        .db    (down_db),
        .press (down_press)
    );

    ripple_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
        .clk   (clk),
        .rst   (rst),
        .raw   (sw_pause),
        .db    (pause_db),
        .press (pause_press)
    );

    assign unused_c = ^{up_db, down_db, pause_press};

    assign period_c = step_period(BASE, level);

`ifdef RIPPLE_SINGLE_STEP_EN
    // While held, "faster" becomes a single-step request and level is frozen
    assign lvl_en_c = (state == RUN);
    assign single_c = (state == HOLD) && up_press;
`else
    assign lvl_en_c = 1'b1;
    assign single_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            level <= '0;
            cnt   <= '0;
            step  <= 1'b0;
        end else begin
            state <= state_n;
            level <= level_n;
            cnt   <= cnt_n;
            step  <= step_n;
        end
    end

    assign paused = (state == HOLD);

    always_comb begin
        state_n = state;
        level_n = level;
        cnt_n   = cnt;
        step_n  = 1'b0;
        hold_c  = 1'b0;

        case (state)
            RUN:     if (pause_db)  state_n = HOLD;
            HOLD:    if (!pause_db) state_n = RUN;
            default: state_n = RUN;
        endcase

        // Freeze on the entry edge too, so no step escapes as paused rises
        hold_c = (state == HOLD) || (state_n == HOLD);

        if (lvl_en_c) begin
            if (up_press && !down_press && (level != LEVEL_W'(MAX_LEVEL))) begin
                level_n = level + LEVEL_W'(1);
            end else if (down_press && !up_press && (level != '0)) begin
                level_n = level - LEVEL_W'(1);
            end
        end

        // Priority: level change, then hold, then terminal count
        if (level_n != level) begin
            cnt_n = '0;
        end else if (hold_c) begin
            step_n = single_c;
        end else if (cnt == (period_c - CNT_W'(1))) begin
            cnt_n  = '0;
            step_n = 1'b1;
        end else begin
            cnt_n = cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ripple_rate_ctrl.sv
// Directed bench for ripple_rate_ctrl with BASE_DIV=64, DB_CYCLES=4.
module tb_ripple_rate_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_up;
    logic       btn_down;
    logic       sw_pause;
    logic       step;
    logic [2:0] level;
    logic       paused;

    int passed;
    int failed;
    int total;
    int n_steps;
    int exp_lvl;
    int nxt_lvl;

    ripple_rate_ctrl #(.BASE_DIV(64), .DB_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .sw_pause (sw_pause),
        .step     (step),
        .level    (level),
        .paused   (paused)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic run_count(input int n, output int s);
        s = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (step === 1'b1) s++;
        end
    endtask

    // Hold the chosen buttons for 20 edges, then release and wait out the debounce
    task automatic hold_btn(input logic up, input logic dn, input int lvl_before, input int lvl_after);
        btn_up   = up;
        btn_down = dn;
        repeat (6) tick();
        check("level_before_press", 32'(level), 32'(lvl_before));
        tick();
        check("level_at_edge7", 32'(level), 32'(lvl_after));
        repeat (13) tick();
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (20) tick();
    endtask

    initial begin
        passed   = 0;
        failed   = 0;
        total    = 0;
        rst      = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        sw_pause = 1'b0;
        tick();
        tick();

        // Reset state and level-0 cadence (period 64)
        check("rst_step", 32'(step), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_paused", 32'(paused), 32'd0);
        check("rst_cnt", dut.cnt, 32'd0);
        rst = 1'b0;
        run_count(63, n_steps);
        check("l0_no_early_step", 32'(n_steps), 32'd0);
        tick();
        check("l0_step_edge64", 32'(step), 32'd1);
        run_count(63, n_steps);
        check("l0_gap", 32'(n_steps), 32'd0);
        tick();
        check("l0_step_edge128", 32'(step), 32'd1);

        // Three holds: 0 -> 1 -> 2 -> 3
        hold_btn(1'b1, 1'b0, 0, 1);
        hold_btn(1'b1, 1'b0, 1, 2);
        btn_up = 1'b1;
        repeat (6) tick();
        check("l3_before", 32'(level), 32'd2);
        tick();
        check("l3_level", 32'(level), 32'd3);
        check("l3_change_no_step", 32'(step), 32'd0);
        run_count(7, n_steps);
        check("l3_gap1", 32'(n_steps), 32'd0);
        tick();
        check("l3_first_step", 32'(step), 32'd1);
        run_count(5, n_steps);
        btn_up = 1'b0;
        run_count(2, n_steps);
        check("l3_gap2", 32'(n_steps), 32'd0);
        tick();
        check("l3_second_step", 32'(step), 32'd1);

        // Pause entered so that cnt freezes at 5
        run_count(7, n_steps);
        sw_pause = 1'b1;
        tick();
        check("pre_pause_step", 32'(step), 32'd1);
        run_count(5, n_steps);
        check("pre_pause_gap", 32'(n_steps), 32'd0);
        tick();
        check("pause_rise", 32'(paused), 32'd1);
        check("pause_rise_step", 32'(step), 32'd0);
        check("pause_cnt", dut.cnt, 32'd5);
        run_count(20, n_steps);
        check("pause_no_steps", 32'(n_steps), 32'd0);
        check("pause_cnt_held", dut.cnt, 32'd5);

        // Resume: first step 3 cycles after paused falls
        sw_pause = 1'b0;
        repeat (6) tick();
        check("resume_still_paused", 32'(paused), 32'd1);
        tick();
        check("resume_paused_fall", 32'(paused), 32'd0);
        run_count(2, n_steps);
        check("resume_gap", 32'(n_steps), 32'd0);
        tick();
        check("resume_step", 32'(step), 32'd1);

        // Second pause, then "faster" held while paused (cnt frozen at 6)
        sw_pause = 1'b1;
        repeat (7) tick();
        check("pause2_rise", 32'(paused), 32'd1);
        check("pause2_cnt", dut.cnt, 32'd6);
        btn_up = 1'b1;
        run_count(6, n_steps);
        check("hold_press_pre", 32'(n_steps), 32'd0);
        tick();
`ifdef RIPPLE_SINGLE_STEP_EN
        check("single_step_pulse", 32'(step), 32'd1);
        check("single_step_level", 32'(level), 32'd3);
        exp_lvl = 3;
`else
        check("hold_press_step", 32'(step), 32'd0);
        check("hold_press_level", 32'(level), 32'd4);
        exp_lvl = 4;
`endif
        run_count(13, n_steps);
        btn_up = 1'b0;
        check("hold_press_post_a", 32'(n_steps), 32'd0);
        run_count(20, n_steps);
        check("hold_press_post_b", 32'(n_steps), 32'd0);
`ifdef RIPPLE_SINGLE_STEP_EN
        check("single_step_cnt", dut.cnt, 32'd6);
`else
        check("hold_press_cnt", dut.cnt, 32'd0);
`endif
        check("hold_level_kept", 32'(level), 32'(exp_lvl));
        sw_pause = 1'b0;
        repeat (15) tick();
        check("pause2_release", 32'(paused), 32'd0);

        // Glitch shorter than DB_CYCLES is rejected
        btn_up = 1'b1;
        repeat (3) tick();
        btn_up = 1'b0;
        repeat (15) tick();
        check("glitch_level", 32'(level), 32'(exp_lvl));

        // Simultaneous up+down leaves level alone
        hold_btn(1'b1, 1'b1, exp_lvl, exp_lvl);

        // Eight holds saturate at 7
        for (int i = 0; i < 8; i++) begin
            nxt_lvl = (exp_lvl < 7) ? exp_lvl + 1 : 7;
            hold_btn(1'b1, 1'b0, exp_lvl, nxt_lvl);
            exp_lvl = nxt_lvl;
        end
        check("sat_level", 32'(level), 32'd7);
        run_count(10, n_steps);
        check("p1_continuous_step", 32'(n_steps), 32'd10);

        // Two down holds: 7 -> 6 -> 5
        hold_btn(1'b0, 1'b1, 7, 6);
        hold_btn(1'b0, 1'b1, 6, 5);

        // One-cycle reset mid-run at level 5
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_step", 32'(step), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_paused", 32'(paused), 32'd0);
        run_count(63, n_steps);
        check("post_rst_gap", 32'(n_steps), 32'd0);
        tick();
        check("post_rst_step64", 32'(step), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ripple_rate_ctrl.md
# ripple_rate_ctrl

Step-rate controller that sits directly upstream of the rippling LED stage and tells it when to advance its pattern. It debounces two push buttons (faster/slower) and a pause switch, keeps a speed level of 0..7, and emits a one-cycle `step` pulse at the rate that level selects. The LED stage advances exactly one position per `step` pulse.

## Interface
- `BASE_DIV`, 50_000_000: step period in clocks at level 0; the period at level L is `BASE_DIV >> L`, floored to 1.
- `DB_CYCLES`, 1_000_000: consecutive stable cycles before a debounced input changes (20 ms at 50 MHz). Must be at least 1.
- `clk`  in  1  system clock; everything is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_up`  in  1  raw "faster" button, asynchronous, active-high.
- `btn_down`  in  1  raw "slower" button, asynchronous, active-high.
- `sw_pause`  in  1  raw pause switch, asynchronous, active-high.
- `step`  out  1  registered, one-cycle advance pulse to the LED stage.
- `level`  out  3  current speed level.
- `paused`  out  1  debounced pause state.

## Operation
- Each raw input goes through a debouncer:
  - A two-flop synchronizer produces `s2`.
  - A counter increments on every edge where `s2` differs from the debounced value `db`, and clears on any edge where they are equal.
  - `db` flips on the DB_CYCLES-th consecutive differing edge.
- Press detection is combinational: `press = db & ~db_q`, where `db_q` is `db` delayed by one cycle.
- Level update at the next edge:
  - An up press increments `level`, saturating at 7.
  - A down press decrements `level`, saturating at 0.
  - Simultaneous up and down presses leave `level` unchanged.
- Prescaler `cnt` (32 bits), with P = max(1, `BASE_DIV >> level`):
  - The level-change edge sets `cnt` to 0 and drives `step` to 0. A level change wins over a terminal count.
  - Else, if `paused` is high: `cnt` holds and `step` is 0. Pause wins over a terminal count.
  - Else, if `cnt == P-1`: `cnt` goes to 0 and `step` goes to 1.
  - Otherwise `cnt` increments and `step` is 0.
- States: RUN (`paused` = 0) and HOLD (`paused` = 1). RUN goes to HOLD when the debounced `sw_pause` rises; HOLD goes to RUN when it falls. On resume, counting continues from the held `cnt`.
- Reset values: `step` 0, `level` 0, `paused` 0, `cnt` 0. All synchronizer, `db`, `db_q` and debounce counters are 0. A reset mid-operation clears everything at the next edge; no `step` is emitted that cycle.

## Timing
- Button to level: if `btn_up` rises before edge 1 and stays stable, `db` rises at edge 2+DB_CYCLES and `level` changes at edge 3+DB_CYCLES.
- Glitch rejection: a raw pulse shorter than DB_CYCLES cycles after synchronization produces no change.
- Step timing from reset release or a level change: the first `step` is high in the cycle after the P-th edge. After that, `step` is high for exactly 1 of every P cycles.
- P = 1 (for example level 7 with a small `BASE_DIV`): `step` stays high continuously while running.
- Pause latency equals button latency. `step` is 0 starting from the edge at which `paused` rises.

## Configuration
- `RIPPLE_SINGLE_STEP_EN` defined:
  - In HOLD, an up press emits exactly one `step` pulse at the next edge and `level` is unchanged.
  - A down press in HOLD is ignored.
  - `cnt` is untouched.
- Not defined: presses in HOLD change `level` as in RUN, and `step` stays 0 throughout HOLD.

## Structure
- Package `ripple_pkg` holds:
  - `LEVEL_W` = 3, `MAX_LEVEL` = 7, `CNT_W` = 32.
  - The `state_t` enum with values RUN and HOLD.
- Sub-module `ripple_debounce` (synchronizer, stability counter, `db`, `db_q`, `press` output) is instantiated three times.
- The top level holds the level register, the prescaler and the state.

## Test plan
All bench scenarios use `BASE_DIV` = 64 and `DB_CYCLES` = 4.
- Reset released with level 0: `step` is high in the cycle after edge 64, then every 64 cycles; `level` = 0 and `paused` = 0.
- `btn_up` held for 20 cycles, three times with gaps: `level` goes 0→1→2→3, each change at edge 7 after the rise; the step period becomes 8.
- `btn_up` pulses of 3 cycles, plus `btn_up` and `btn_down` pressed simultaneously: `level` stays unchanged. With 8 separate holds on `btn_up`, `level` saturates at 7 and `step` is high continuously.
- `sw_pause` raised with `cnt` = 5 at level 3: `step` stays 0 and `cnt` holds 5 while paused. After release, the first `step` comes 3 cycles after `paused` falls.
- `rst` pulsed for one cycle at level 5 while running: at the next edge `step`, `level` and `paused` are 0, and counting restarts with period 64.
- With `RIPPLE_SINGLE_STEP_EN` defined, paused, `btn_up` held for 20 cycles: exactly one `step` at edge 7 and `level` unchanged.
